// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared constants for the ALU gate-level datapath units.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Native datapath width of the ALU
  localparam int DATA_WIDTH = 32;

  // Handy full-width patterns for the datapath
  localparam logic [DATA_WIDTH-1:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [DATA_WIDTH-1:0] ONES_WORD = 32'hFFFF_FFFF;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/and32_unit_and_bit.sv
`default_nettype none
// ============================================================================
//  Module      : and_bit
//  Description : Single-bit two-input AND gate; the leaf cell the AND unit is
//                built from.
//  Revision    : 1.0 - initial release
// ============================================================================
module and_bit (
  input  logic a,
  input  logic b,
  output logic y
);

  // Pure gate: no state, no clock
  assign y = a & b;

endmodule : and_bit
`default_nettype wire

// File: rtl/and32_unit.sv
`default_nettype none
// ============================================================================
//  Module      : and32_unit
//  Description : Bitwise AND datapath element. F is the combinational
//                A & B; F_q/zero_q/out_valid are a one-cycle registered copy
//                for use at a pipeline-stage boundary.
//  Revision    : 1.0 - initial release
// ============================================================================
module and32_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic [WIDTH-1:0] F,
  output logic [WIDTH-1:0] F_q,
  output logic             out_valid,
  output logic             zero_q
);

  logic [WIDTH-1:0] w_f;
  logic             w_is_zero;
  logic [WIDTH-1:0] r_f_q;
  logic             r_zero_q;
  logic             r_out_valid;

  // One gate per bit, mirroring the other structural ALU gate units
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      and_bit u_and_bit (
        .a (A[i]),
        .b (B[i]),
        .y (w_f[i])
      );
    end
  endgenerate

  // Zero detect on the combinational result, registered alongside it
  assign w_is_zero = (w_f == {WIDTH{1'b0}});

  // Result register: load on an accepted operation, otherwise hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_f_q <= {WIDTH{1'b0}};
    end else if (in_valid) begin
      r_f_q <= w_f;
    end
  end

  // Zero flag register: tracks the result register's load enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_zero_q <= 1'b0;
    end else if (in_valid) begin
      r_zero_q <= w_is_zero;
    end
  end

  // Valid register: one-cycle pulse per accepted operation, no backpressure
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
    end
  end

  assign F         = w_f;
  assign F_q       = r_f_q;
  assign zero_q    = r_zero_q;
  assign out_valid = r_out_valid;

endmodule : and32_unit
`default_nettype wire

// File: tb/tb_and32_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_and32_unit
//  Description : Self-checking bench for and32_unit: vector table for the
//                combinational and registered paths, scoreboard queue for
//                registered results, hand sequences for reset corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_and32_unit;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         valid;
    logic [W-1:0] exp_f;
    logic         exp_zero;
  } vec_t;

  typedef struct {
    logic [W-1:0] f;
    logic         z;
  } exp_t;

  logic         clk;
  logic         reset;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         in_valid;
  logic [W-1:0] F;
  logic [W-1:0] F_q;
  logic         out_valid;
  logic         zero_q;

  int n_pass  = 0;
  int n_total = 0;

  exp_t sb[$];
  exp_t held;
  vec_t vecs[11];

  and32_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .A         (A),
    .B         (B),
    .in_valid  (in_valid),
    .F         (F),
    .F_q       (F_q),
    .out_valid (out_valid),
    .zero_q    (zero_q)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Compare registered outputs against the scoreboard (or the held value)
  task automatic check_registered(input string tag, input logic exp_valid);
    exp_t e;
    check({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, exp_valid});
    if (out_valid) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL %s scoreboard: out_valid=1 with no expected result queued", tag);
      end else begin
        e = sb.pop_front();
        held = e;
      end
    end
    check({tag, " F_q"}, F_q, held.f);
    check({tag, " zero_q"}, {31'd0, zero_q}, {31'd0, held.z});
  endtask

  // Drive one operation at the falling edge, check F, clock it, check registers
  task automatic apply(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic v, input logic [W-1:0] exp_f, input logic exp_z);
    exp_t e;
    @(negedge clk);
    A = a; B = b; in_valid = v;
    #1;
    check({tag, " F"}, F, exp_f);
    if (v) begin
      e.f = exp_f; e.z = exp_z;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    check_registered(tag, v);
  endtask

  initial begin
    vecs[0]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
    vecs[1]  = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'h0000_0000, 1'b1};
    vecs[2]  = '{32'h0000_0001, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
    vecs[3]  = '{32'h0000_0001, 32'h0000_0001, 1'b1, 32'h0000_0001, 1'b0};
    vecs[4]  = '{32'hFFFF_FFFF, 32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5, 1'b0};
    vecs[5]  = '{32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b1, 32'h0000_0000, 1'b1};
    vecs[6]  = '{32'h1234_5678, 32'hFFFF_0000, 1'b0, 32'h1234_0000, 1'b0};
    vecs[7]  = '{32'hFFFF_FFFF, 32'h0000_FFFF, 1'b0, 32'h0000_FFFF, 1'b0};
    vecs[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0};
    vecs[9]  = '{32'h8000_0001, 32'h8000_0000, 1'b1, 32'h8000_0000, 1'b0};
    vecs[10] = '{32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};

    held.f = '0; held.z = 1'b0;
    reset = 1'b1; A = '0; B = '0; in_valid = 1'b0;

    // Reset state, including across a clock edge with a valid op presented
    @(negedge clk);
    A = 32'h0000_00FF; B = 32'h0000_000F; in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("reset F_q", F_q, 32'h0);
    check("reset zero_q", {31'd0, zero_q}, 32'h0);
    check("reset out_valid", {31'd0, out_valid}, 32'h0);
    check("reset F comb", F, 32'h0000_000F);

    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 11; i++) begin
      apply($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].valid,
            vecs[i].exp_f, vecs[i].exp_zero);
    end

    // Load 0xA5A5A5A5, then assert reset between edges with an op in flight
    apply("pre_rst", 32'hFFFF_FFFF, 32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5, 1'b0);
    @(negedge clk);
    A = 32'h0000_0003; B = 32'h0000_0006; in_valid = 1'b1;
    #2;
    reset = 1'b1;
    sb.delete();
    held.f = '0; held.z = 1'b0;
    #1;
    check("async_rst F_q", F_q, 32'h0);
    check("async_rst zero_q", {31'd0, zero_q}, 32'h0);
    check("async_rst out_valid", {31'd0, out_valid}, 32'h0);
    check("async_rst F comb", F, 32'h0000_0002);

    // Deassert with no valid: first edge produces nothing
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_registered("post_rst idle", 1'b0);

    // First valid op after reset appears one edge later
    apply("post_rst op", 32'h0000_0003, 32'h0000_0006, 1'b1, 32'h0000_0002, 1'b0);
    apply("post_rst tail", 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0);

    n_total++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard drain: %0d results left, expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_and32_unit
`default_nettype wire

// File: doc/and32_unit.md
Name: and32_unit

Overview:
- 32-bit bitwise AND datapath element for the pipelined processor ALU.
- Produces a combinational result F = A & B.
- Also provides a one-cycle registered copy of the result, with a valid flag and a zero flag, for use at a pipeline-stage boundary.
- Pure logic: no arithmetic, carries or sign handling.

Parameters:
- WIDTH, 32, operand/result width in bits; the spec and tests assume 32.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- F  output  WIDTH  combinational result, A & B
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- in_valid  input  1  marks A/B as a valid operation this cycle
- F_q  output  WIDTH  registered result
- out_valid  output  1  F_q holds a valid result
- zero_q  output  1  registered flag: F_q == 0 (meaningful only when out_valid = 1)

Behaviour:
- Clock and reset (already decided): one clock; reset is asynchronous and active-high.
- Combinational path:
  - F[i] = A[i] & B[i] for every bit i, with no clock dependence.
  - F settles within the same delta/cycle as A or B changes.
  - F is unaffected by reset and by in_valid.
- Registered path, on the rising edge of clk when reset = 0:
  - F_q <= A & B when in_valid = 1; F_q holds its value when in_valid = 0.
  - zero_q <= ((A & B) == 0) when in_valid = 1; holds otherwise.
  - out_valid <= in_valid every cycle (single-cycle pulse per accepted operation).
- Latency: combinational F = 0 cycles; registered outputs = 1 cycle.
- No backpressure: every valid input is accepted, and back-to-back valid cycles produce back-to-back results.
- Reset:
  - While reset = 1: F_q = 0, zero_q = 0, out_valid = 0, applied immediately, independent of clk.
  - Reset asserted mid-operation discards the in-flight result. The first cycle after deassertion produces no output unless in_valid is sampled high at that edge.
- X/Z inputs are not specially handled; the logical AND propagates them.
- Boundary cases:
  - A or B all-zeros gives F = 0 and zero flag 1.
  - A = B = all-ones gives F = 0xFFFFFFFF and zero flag 0.
  - Single-bit overlap: F has exactly that bit set.
- No internal state beyond the three output registers.

Decomposition:
- Shared package (alu_pkg):
  - constant DATA_WIDTH = 32
  - constant ZERO_WORD = 32'h0000_0000
  - constant ONES_WORD = 32'hFFFF_FFFF
- Sub-module and_bit: a 1-bit 2-input AND (y = a & b).
  - Instantiated WIDTH times via generate to form F, matching the structural style of the other ALU gate-level units.
- The register stage stays in the top module.

Test Plan:
- A=0, B=0, in_valid=1 -> F=0x00000000 immediately; next edge F_q=0, zero_q=1, out_valid=1.
- A=0, B=1 then A=1, B=0 -> F=0x00000000 in both cases; zero_q=1 after each edge.
- A=1, B=1 -> F=0x00000001; next edge F_q=0x00000001, zero_q=0.
- A=0xFFFFFFFF with B=0xA5A5A5A5, then A=0xF0F0F0F0 with B=0x0F0F0F0F, on back-to-back valid cycles -> F_q=0xA5A5A5A5 (zero_q=0), then 0x00000000 (zero_q=1); out_valid high both cycles.
- in_valid=0 with A/B changing -> F tracks A & B combinationally; F_q and zero_q hold; out_valid=0.
- Assert reset between clock edges with F_q=0xA5A5A5A5 -> F_q=0, zero_q=0, out_valid=0 immediately without a clock edge; F still equals A & B; after deassertion the first valid op appears one edge later.
